updown_counter_p: RTL and testbench

- Parametrised up/down counter for game timing and position stepping, e.g. player coordinates, speed ticks and score.
- Generalises the fixed 10-bit onoff/pm counter with these additions:
  - configurable width, bounds and step;
  - built-in prescaler;
  - wrap or saturate mode;
  - synchronous clear and load;
  - boundary flags and terminal-count pulse.
- Sits between the game FSM and the VGA pixel/sprite logic, all in one clock domain.

---
 rtl/updown_counter_p_if.sv | 28 ++
 rtl/updown_counter_p.sv | 151 +++++++++++++++
 tb/tb_updown_counter_p.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/updown_counter_p_if.sv
// Control/status bundle for updown_counter_p.
//   master : game FSM side; drives onoff, pm, clr, load, load_val and
//            observes q, tc, at_max, at_min.
//   slave  : counter side; the mirror image.
// WIDTH must match the WIDTH of the counter the bundle is connected to.
interface updown_counter_p_if #(
    parameter int unsigned WIDTH = 10
);
    logic             onoff;
    logic             pm;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             at_max;
    logic             at_min;

    modport master (
        output onoff, pm, clr, load, load_val,
        input  q, tc, at_max, at_min
    );

    modport slave (
        input  onoff, pm, clr, load, load_val,
        output q, tc, at_max, at_min
    );
endinterface

// File: rtl/updown_counter_p.sv
// Parametrised up/down counter with prescaler, wrap/saturate mode,
// synchronous clear/load, boundary flags and a terminal-count pulse.
// Used for player coordinates, speed ticks and score.
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   bus.onoff     count enable; 0 freezes q and the prescaler
//   bus.pm        direction: 1 = up, 0 = down (sampled on the step edge)
//   bus.clr       synchronous clear to RESET_VAL (highest priority)
//   bus.load      synchronous load of load_val, clamped into [MIN,MAX]
//   bus.load_val  value to load
//   bus.q         registered counter value
//   bus.tc        registered one-clock pulse on a step that wrapped/clamped
//   bus.at_max    q == MAX (combinational from q)
//   bus.at_min    q == MIN (combinational from q)
module updown_counter_p #(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned MIN       = 0,
    parameter int unsigned MAX       = 1023,
    parameter int unsigned STEP      = 1,
    parameter int unsigned DIV       = 1,
    parameter int unsigned WRAP      = 1,
    parameter int unsigned RESET_VAL = MIN
) (
    input  logic                clk,
    input  logic                reset_n,
    updown_counter_p_if.slave   bus
);

    // Elaboration-time parameter legality checks.
    generate
        if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
            $error("updown_counter_p: WIDTH must be 1..31");
        end
        if (MIN >= MAX || 64'(MAX) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_range
            $error("updown_counter_p: need MIN < MAX <= 2**WIDTH-1");
        end
        if (STEP < 1 || STEP > MAX - MIN) begin : g_bad_step
            $error("updown_counter_p: need 1 <= STEP <= MAX-MIN");
        end
        if (DIV < 1) begin : g_bad_div
            $error("updown_counter_p: need DIV >= 1");
        end
        if (WRAP > 1) begin : g_bad_wrap
            $error("updown_counter_p: WRAP must be 0 or 1");
        end
        if (RESET_VAL < MIN || RESET_VAL > MAX) begin : g_bad_reset
            $error("updown_counter_p: need MIN <= RESET_VAL <= MAX");
        end
    endgenerate

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    // WIDTH+1-bit forms so step arithmetic never overflows.
    localparam logic [WIDTH:0]   MIN_X    = (WIDTH+1)'(MIN);
    localparam logic [WIDTH:0]   MAX_X    = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   SPAN_X   = (WIDTH+1)'(MAX - MIN + 1);
    localparam logic [WIDTH-1:0] MIN_Q    = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RST_Q    = WIDTH'(RESET_VAL);
    localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);

    logic [WIDTH-1:0]        q_r;
    logic [PW-1:0]           pre_r;
    logic                    tc_r;

    logic [WIDTH:0]          up_sum;
    logic signed [WIDTH:0]   dn_diff;
    logic                    up_over;
    logic                    dn_under;
    logic [WIDTH-1:0]        step_q;
    logic                    step_crossed;
    logic [WIDTH:0]          lv_x;
    logic [WIDTH-1:0]        load_q;
    logic                    pre_last;

    // Next value for a step, plus whether it crossed a bound.
    // Down steps use a signed compare so q-STEP below zero is caught.
    // SPAN_X may equal 2**WIDTH (negative as a signed WIDTH+1 value); the
    // wrap add is done modulo 2**(WIDTH+1), so the low WIDTH bits are exact.
    always_comb begin
        up_sum       = {1'b0, q_r} + STEP_X;
        dn_diff      = $signed({1'b0, q_r}) - $signed(STEP_X);
        up_over      = (up_sum > MAX_X);
        dn_under     = (dn_diff < $signed(MIN_X));
        step_q       = q_r;
        step_crossed = 1'b0;
        if (bus.pm) begin
            if (!up_over) begin
                step_q = up_sum[WIDTH-1:0];
            end else begin
                step_crossed = 1'b1;
                step_q       = (WRAP != 0) ? WIDTH'(up_sum - SPAN_X) : MAX_Q;
            end
        end else begin
            if (!dn_under) begin
                step_q = WIDTH'($unsigned(dn_diff));
            end else begin
                step_crossed = 1'b1;
                step_q       = (WRAP != 0) ? WIDTH'($unsigned(dn_diff) + SPAN_X) : MIN_Q;
            end
        end
    end

    // Clamp load_val into [MIN,MAX].
    always_comb begin
        lv_x = {1'b0, bus.load_val};
        if (lv_x < MIN_X) begin
            load_q = MIN_Q;
        end else if (lv_x > MAX_X) begin
            load_q = MAX_Q;
        end else begin
            load_q = bus.load_val;
        end
    end

    assign pre_last = (pre_r == PRE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r   <= RST_Q;
            pre_r <= '0;
            tc_r  <= 1'b0;
        end else begin
            tc_r <= 1'b0;
            if (bus.clr) begin
                q_r   <= RST_Q;
                pre_r <= '0;
            end else if (bus.load) begin
                q_r   <= load_q;
                pre_r <= '0;
            end else if (bus.onoff) begin
                if (pre_last) begin
                    pre_r <= '0;
                    q_r   <= step_q;
                    tc_r  <= step_crossed;
                end else begin
                    pre_r <= pre_r + PW'(1);
                end
            end
        end
    end

    assign bus.q      = q_r;
    assign bus.tc     = tc_r;
    assign bus.at_max = (q_r == MAX_Q);
    assign bus.at_min = (q_r == MIN_Q);

endmodule

// File: tb/tb_updown_counter_p.sv
// Bench for updown_counter_p: five instances with different parameter
// sets share clk/reset_n; one instance is exercised at a time. Expected
// results are queued when an edge is driven and compared just after it.
module tb_updown_counter_p;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    updown_counter_p_if #(.WIDTH(10)) b_def ();
    updown_counter_p_if #(.WIDTH(10)) b_sat ();
    updown_counter_p_if #(.WIDTH(10)) b_div ();
    updown_counter_p_if #(.WIDTH(10)) b_rng ();
    updown_counter_p_if #(.WIDTH(4))  b_stp ();

    updown_counter_p u_def (.clk(clk), .reset_n(reset_n), .bus(b_def));
    updown_counter_p #(.WRAP(0)) u_sat (.clk(clk), .reset_n(reset_n), .bus(b_sat));
    updown_counter_p #(.DIV(4)) u_div (.clk(clk), .reset_n(reset_n), .bus(b_div));
    updown_counter_p #(.MIN(100), .MAX(900)) u_rng (.clk(clk), .reset_n(reset_n), .bus(b_rng));
    updown_counter_p #(.WIDTH(4), .MIN(0), .MAX(9), .STEP(3), .WRAP(1))
        u_stp (.clk(clk), .reset_n(reset_n), .bus(b_stp));

    typedef struct {
        int sel;
        int q;
        int tc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   max_of [5] = '{1023, 1023, 1023, 900, 9};
    int   min_of [5] = '{0, 0, 0, 100, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_q(input int sel);
        case (sel)
            0:       return 32'(b_def.q);
            1:       return 32'(b_sat.q);
            2:       return 32'(b_div.q);
            3:       return 32'(b_rng.q);
            default: return 32'(b_stp.q);
        endcase
    endfunction

    function automatic logic [31:0] obs_tc(input int sel);
        case (sel)
            0:       return 32'(b_def.tc);
            1:       return 32'(b_sat.tc);
            2:       return 32'(b_div.tc);
            3:       return 32'(b_rng.tc);
            default: return 32'(b_stp.tc);
        endcase
    endfunction

    function automatic logic [31:0] obs_amax(input int sel);
        case (sel)
            0:       return 32'(b_def.at_max);
            1:       return 32'(b_sat.at_max);
            2:       return 32'(b_div.at_max);
            3:       return 32'(b_rng.at_max);
            default: return 32'(b_stp.at_max);
        endcase
    endfunction

    function automatic logic [31:0] obs_amin(input int sel);
        case (sel)
            0:       return 32'(b_def.at_min);
            1:       return 32'(b_sat.at_min);
            2:       return 32'(b_div.at_min);
            3:       return 32'(b_rng.at_min);
            default: return 32'(b_stp.at_min);
        endcase
    endfunction

    // Scoreboard consumer: one queued expectation per driven edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check($sformatf("d%0d_q", e.sel), obs_q(e.sel), 32'(e.q));
            check($sformatf("d%0d_tc", e.sel), obs_tc(e.sel), 32'(e.tc));
            check($sformatf("d%0d_atmax", e.sel), obs_amax(e.sel), 32'(e.q == max_of[e.sel]));
            check($sformatf("d%0d_atmin", e.sel), obs_amin(e.sel), 32'(e.q == min_of[e.sel]));
        end
    end

    // Queue the expectation for the coming edge, then move to the next negedge.
    task automatic tick_exp(input int sel, input int q, input int tc);
        exp_t e;
        e.sel = sel;
        e.q   = q;
        e.tc  = tc;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        b_def.onoff = 1'b0; b_def.pm = 1'b0; b_def.clr = 1'b0; b_def.load = 1'b0; b_def.load_val = '0;
        b_sat.onoff = 1'b0; b_sat.pm = 1'b0; b_sat.clr = 1'b0; b_sat.load = 1'b0; b_sat.load_val = '0;
        b_div.onoff = 1'b0; b_div.pm = 1'b0; b_div.clr = 1'b0; b_div.load = 1'b0; b_div.load_val = '0;
        b_rng.onoff = 1'b0; b_rng.pm = 1'b0; b_rng.clr = 1'b0; b_rng.load = 1'b0; b_rng.load_val = '0;
        b_stp.onoff = 1'b0; b_stp.pm = 1'b0; b_stp.clr = 1'b0; b_stp.load = 1'b0; b_stp.load_val = '0;

        // Reset state.
        #12;
        check("rst_def_q", obs_q(0), 32'd0);
        check("rst_def_tc", obs_tc(0), 32'd0);
        check("rst_rng_q", obs_q(3), 32'd100);
        check("rst_stp_q", obs_q(4), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: count to 37, async reset mid-run, resume.
        b_def.onoff = 1'b1;
        b_def.pm    = 1'b1;
        for (int i = 1; i <= 37; i++) tick_exp(0, i, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t1_async_q", obs_q(0), 32'd0);
        check("t1_async_tc", obs_tc(0), 32'd0);
        check("t1_async_atmin", obs_amin(0), 32'd1);
        @(posedge clk);
        #1;
        check("t1_hold_q", obs_q(0), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) tick_exp(0, i, 0);
        b_def.onoff = 1'b0;

        // 2: wrap at the top.
        b_def.load     = 1'b1;
        b_def.load_val = 10'd1022;
        tick_exp(0, 1022, 0);
        b_def.load  = 1'b0;
        b_def.onoff = 1'b1;
        tick_exp(0, 1023, 0);
        tick_exp(0, 0, 1);
        tick_exp(0, 1, 0);
        b_def.onoff = 1'b0;
        tick_exp(0, 1, 0);

        // 3: saturate at the bottom; tc repeats while held at the bound.
        b_sat.load     = 1'b1;
        b_sat.load_val = 10'd1;
        tick_exp(1, 1, 0);
        b_sat.load  = 1'b0;
        b_sat.onoff = 1'b1;
        b_sat.pm    = 1'b0;
        tick_exp(1, 0, 0);
        tick_exp(1, 0, 1);
        tick_exp(1, 0, 1);
        b_sat.onoff = 1'b0;
        tick_exp(1, 0, 0);

        // 4: prescaler DIV=4, freeze with onoff=0, direction sampled at the step.
        b_div.onoff = 1'b1;
        b_div.pm    = 1'b1;
        tick_exp(2, 0, 0);
        tick_exp(2, 0, 0);
        tick_exp(2, 0, 0);
        tick_exp(2, 1, 0);
        b_div.pm = 1'b0;
        tick_exp(2, 1, 0);
        tick_exp(2, 1, 0);
        b_div.onoff = 1'b0;
        for (int i = 0; i < 3; i++) tick_exp(2, 1, 0);
        b_div.onoff = 1'b1;
        b_div.pm    = 1'b1;
        tick_exp(2, 1, 0);
        tick_exp(2, 2, 0);
        b_div.onoff = 1'b0;

        // 5: load clamping, clr over load, down-wrap at MIN.
        b_rng.load     = 1'b1;
        b_rng.load_val = 10'd950;
        tick_exp(3, 900, 0);
        b_rng.load_val = 10'd50;
        tick_exp(3, 100, 0);
        b_rng.load_val = 10'd500;
        tick_exp(3, 500, 0);
        b_rng.clr = 1'b1;
        tick_exp(3, 100, 0);
        b_rng.clr   = 1'b0;
        b_rng.load  = 1'b0;
        b_rng.onoff = 1'b1;
        b_rng.pm    = 1'b0;
        tick_exp(3, 900, 1);
        tick_exp(3, 899, 0);
        b_rng.onoff = 1'b0;

        // 6: STEP=3 over [0,9] with wrap in both directions.
        b_stp.load     = 1'b1;
        b_stp.load_val = 4'd9;
        tick_exp(4, 9, 0);
        b_stp.load  = 1'b0;
        b_stp.onoff = 1'b1;
        b_stp.pm    = 1'b1;
        tick_exp(4, 2, 1);
        b_stp.pm = 1'b0;
        tick_exp(4, 9, 1);
        tick_exp(4, 6, 0);
        tick_exp(4, 3, 0);
        tick_exp(4, 0, 0);
        tick_exp(4, 7, 1);
        b_stp.onoff = 1'b0;

        @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
